// File: rtl/reed_solomon_decoder_pkg.sv
// -----------------------------------------------------------------------------
// reed_solomon_decoder_pkg
// Shared GF(2^8) definitions for the Reed-Solomon decoder core.
//   RS_GF_POLY   : primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02
//   RS_N_DEFAULT : default codeword length in bytes
//   RS_T_DEFAULT : default number of correctable symbols
//   t_rs_symbol  : one GF(2^8) symbol
//   gf_xtime     : multiply a symbol by alpha
//   gf_mul_xpow  : multiply a symbol by alpha^k (k >= 0), by repeated xtime
//   gf_alpha_pow : alpha^e for any integer e, intended for elaboration time
// -----------------------------------------------------------------------------
package reed_solomon_decoder_pkg;

  localparam logic [8:0] RS_GF_POLY   = 9'h11D;
  localparam int         RS_N_DEFAULT = 255;
  localparam int         RS_T_DEFAULT = 16;

  typedef logic [7:0] t_rs_symbol;

  function automatic t_rs_symbol gf_xtime(input t_rs_symbol a);
    logic [8:0] w_shift;
    w_shift = {a, 1'b0};
    if (a[7]) w_shift = w_shift ^ RS_GF_POLY;
    return w_shift[7:0];
  endfunction

  function automatic t_rs_symbol gf_mul_xpow(input t_rs_symbol a, input int k);
    t_rs_symbol w_acc;
    w_acc = a;
    for (int n = 0; n < k; n++) w_acc = gf_xtime(w_acc);
    return w_acc;
  endfunction

  // The multiplicative group has order 255, so the exponent is reduced mod 255
  // (negative exponents wrap to their positive equivalent).
  function automatic t_rs_symbol gf_alpha_pow(input int e);
    int m;
    m = e % 255;
    if (m < 0) m = m + 255;
    return gf_mul_xpow(8'h01, m);
  endfunction

endpackage

// File: rtl/reed_solomon_gf_mul_const.sv
// -----------------------------------------------------------------------------
// reed_solomon_gf_mul_const
// Combinational multiply of a GF(2^8) symbol by a constant fixed at
// elaboration. The constant's products with alpha^0..alpha^7 are computed at
// elaboration by repeated xtime; the product is then the XOR of those terms
// selected by the bits of the input symbol.
//   CONST_VAL : the constant multiplier
//   i_a       : input symbol
//   o_p       : i_a * CONST_VAL in GF(2^8)
// -----------------------------------------------------------------------------
module reed_solomon_gf_mul_const
  import reed_solomon_decoder_pkg::*;
#(
  parameter t_rs_symbol CONST_VAL = 8'h01
) (
  input  t_rs_symbol i_a,
  output t_rs_symbol o_p
);

  t_rs_symbol w_terms [8];

  for (genvar k = 0; k < 8; k++) begin : g_term
    localparam t_rs_symbol K_TERM = gf_mul_xpow(CONST_VAL, k);
    assign w_terms[k] = i_a[k] ? K_TERM : '0;
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_p = '0;
    for (int k = 0; k < 8; k++) o_p = o_p ^ w_terms[k];
  end

endmodule

// File: rtl/reed_solomon_decoder_syndrome.sv
// -----------------------------------------------------------------------------
// reed_solomon_decoder_syndrome
// Syndrome stage of the RS decoder. Consumes the received codeword one byte
// per valid_in (first byte = highest-degree coefficient) and evaluates the
// 2*RS_T syndromes S_i = r(alpha^(FCR+i)) by Horner's rule. Completed sets are
// handed downstream through a single valid/ready output register.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of partial codeword and output slot
//   data_in      : received symbol, qualified by valid_in (no backpressure)
//   syn_out      : syndrome i at bits [8i+7:8i]
//   syn_valid    : syn_out holds an unconsumed result
//   syn_ready    : downstream accepts syn_out
//   no_error     : all syndromes zero, qualified by syn_valid
//   overflow     : sticky, a completed set was dropped because the slot was full
//   byte_cnt     : bytes received in the current codeword
// -----------------------------------------------------------------------------
module reed_solomon_decoder_syndrome
  import reed_solomon_decoder_pkg::*;
#(
  parameter int RS_N = RS_N_DEFAULT,
  parameter int RS_T = RS_T_DEFAULT,
  parameter int FCR  = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [7:0]                data_in,
  input  logic                      valid_in,
  output logic [2*RS_T*8-1:0]       syn_out,
  output logic                      syn_valid,
  input  logic                      syn_ready,
  output logic                      no_error,
  output logic                      overflow,
  output logic [$clog2(RS_N)-1:0]   byte_cnt
);

  localparam int                NSYN     = 2 * RS_T;
  localparam int                CW       = $clog2(RS_N);
  localparam logic [CW-1:0]     LAST_CNT = CW'(RS_N - 1);

  logic [NSYN-1:0][7:0] r_acc;
  logic [NSYN-1:0][7:0] w_prod;
  logic [NSYN-1:0][7:0] w_next;
  logic [CW-1:0]        r_byte_cnt;
  logic [2*RS_T*8-1:0]  r_syn_out;
  logic                 r_syn_valid;
  logic                 r_no_error;
  logic                 r_overflow;
  logic                 w_last;
  logic                 w_all_zero;
  logic                 w_slot_free;

  // One Horner step per syndrome: next = acc * alpha^(FCR+i) ^ data_in.
  for (genvar i = 0; i < NSYN; i++) begin : g_syn
    reed_solomon_gf_mul_const #(
      .CONST_VAL (gf_alpha_pow(FCR + i))
    ) u_mul (
      .i_a (r_acc[i]),
      .o_p (w_prod[i])
    );
    assign w_next[i] = w_prod[i] ^ data_in;
  end

  assign w_last      = (r_byte_cnt == LAST_CNT);
  assign w_all_zero  = (w_next == '0);
  // The slot can take a new set if empty or being drained on this same edge.
  assign w_slot_free = !r_syn_valid || syn_ready;

  // Accumulators and byte counter.
  // NOTE: the accumulator array is reset explicitly: a reset released
  // mid-codeword must restart Horner's rule from zero, not from stale partials.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_byte_cnt <= '0;
    end else if (flush) begin
      r_acc      <= '0;
      r_byte_cnt <= '0;
    end else if (valid_in) begin
      if (w_last) begin
        r_acc      <= '0;
        r_byte_cnt <= '0;
      end else begin
        r_acc      <= w_next;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
    end
  end

  // Output slot: syn_out/no_error only load when a completed set is accepted,
  // so they are frozen whenever the slot is full and not being drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_syn_out   <= '0;
      r_syn_valid <= 1'b0;
      r_no_error  <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (flush) begin
      r_syn_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_syn_valid && syn_ready) r_syn_valid <= 1'b0;
      if (valid_in && w_last) begin
        if (w_slot_free) begin
          r_syn_out   <= w_next;
          r_no_error  <= w_all_zero;
          r_syn_valid <= 1'b1;
        end else begin
          r_overflow  <= 1'b1;
        end
      end
    end
  end

  assign syn_out   = r_syn_out;
  assign syn_valid = r_syn_valid;
  assign no_error  = r_no_error;
  assign overflow  = r_overflow;
  assign byte_cnt  = r_byte_cnt;

endmodule
